// File: rtl/stepper_regs_pkg.sv
// stepper_regs_pkg: register map shared by the step/dir monitor and the stepper controller
package stepper_regs_pkg;
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_POSITION = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_TARGET   = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;
  localparam logic [2:0] ADDR_TIMEOUT  = 3'd5;
  localparam logic [2:0] ADDR_STEPCNT  = 3'd6;
  localparam logic [2:0] ADDR_ID       = 3'd7;
  localparam int CTRL_COUNT_EN = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_DIR_INV  = 2;
  localparam int CTRL_POS_CLR  = 3;
  localparam int STATUS_HIT    = 0;
  localparam logic [31:0] ID_VALUE = 32'h5344_4D31;
  typedef struct packed {
    logic dir_inv;
    logic irq_en;
    logic count_en;
  } ctrl_t;
  typedef struct packed {
    logic en;
    logic pvalid;
    logic stalled;
    logic hit;
  } status_t;
endpackage

// File: rtl/step_dir_monitor_if.sv
// step_dir_monitor_if: Avalon-MM slave bus of the step/dir monitor
interface step_dir_monitor_if;
  logic        avs_cs;
  logic        avs_read;
  logic        avs_write;
  logic [2:0]  avs_address;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  modport master (output avs_cs, avs_read, avs_write, avs_address, avs_writedata, input avs_readdata);
  modport slave (input avs_cs, avs_read, avs_write, avs_address, avs_writedata, output avs_readdata);
endinterface

// File: rtl/sd_sync.sv
// sd_sync: 2-FF synchronizer with rising-edge detect on i_edge, equal-depth sync for i_lvl
module sd_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_edge,
  input  logic [W-1:0] i_lvl,
  output logic         o_rise,
  output logic [W-1:0] o_lvl
);
  logic [W:0] r_meta, r_sync;
  logic       r_prev;
  logic [2:0] r_vld;
  // r_vld gates the edge until r_prev holds a real sample, so a level already high at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= 1'b0;
      r_vld  <= '0;
    end else begin
      r_meta <= {i_lvl, i_edge};
      r_sync <= r_meta;
      r_prev <= r_sync[0];
      r_vld  <= {r_vld[1:0], 1'b1};
    end
  end
  assign o_rise = r_sync[0] & ~r_prev & r_vld[2];
  assign o_lvl  = r_sync[W:1];
endmodule

// File: rtl/step_dir_monitor.sv
// step_dir_monitor: counts stepper drive step/dir pulses into position, step count, period and stall status
module step_dir_monitor
  import stepper_regs_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1_000_000
) (
  input  logic              avs_clk,
  input  logic              avs_reset_n,
  step_dir_monitor_if.slave avs,
  input  logic              step_in,
  input  logic              dir_in,
  input  logic              en_in,
  output logic              irq
);
  ctrl_t       r_ctrl;
  logic [31:0] r_pos, r_period, r_target, r_timeout, r_stepcnt, r_pcnt, r_rdata;
  logic        r_hit, r_pvalid;
  logic        w_rise, w_dir, w_en, w_wr, w_step, w_pos_wr, w_count_rise;
  logic [7:0]  w_sel;
  logic [31:0] w_wd, w_pos_next, w_rdata;
  status_t     w_status;
  sd_sync #(.W(2)) u_sync (
    .clk    (avs_clk),
    .rst_n  (avs_reset_n),
    .i_edge (step_in),
    .i_lvl  ({en_in, dir_in}),
    .o_rise (w_rise),
    .o_lvl  ({w_en, w_dir})
  );
  assign w_wd         = avs.avs_writedata;
  assign w_wr         = avs.avs_cs & avs.avs_write;
  assign w_sel        = w_wr ? 8'(1) << avs.avs_address : '0;
  assign w_step       = w_rise & w_en & r_ctrl.count_en;
  assign w_pos_next   = r_pos + ((w_dir ^ r_ctrl.dir_inv) ? 32'd1 : '1);
  assign w_pos_wr     = w_sel[ADDR_POSITION] | (w_sel[ADDR_CTRL] & w_wd[CTRL_POS_CLR]);
  assign w_count_rise = w_sel[ADDR_CTRL] & w_wd[CTRL_COUNT_EN] & ~r_ctrl.count_en;
  assign w_status     = status_t'({w_en, r_pvalid, r_pcnt >= r_timeout, r_hit});
  assign irq          = r_hit & r_ctrl.irq_en;
  assign avs.avs_readdata = r_rdata;
  always_comb begin
    w_rdata = '0;
    case (avs.avs_address)
      ADDR_CTRL:     w_rdata = {29'd0, r_ctrl};
      ADDR_POSITION: w_rdata = r_pos;
      ADDR_PERIOD:   w_rdata = r_period;
      ADDR_TARGET:   w_rdata = r_target;
      ADDR_STATUS:   w_rdata = {28'd0, w_status};
      ADDR_TIMEOUT:  w_rdata = r_timeout;
      ADDR_STEPCNT:  w_rdata = r_stepcnt;
      default:       w_rdata = ID_VALUE;
    endcase
  end
  always_ff @(posedge avs_clk or negedge avs_reset_n) begin
    if (!avs_reset_n) begin
      r_ctrl    <= '0;
      r_pos     <= '0;
      r_period  <= '0;
      r_target  <= '0;
      r_timeout <= TIMEOUT_DEFAULT;
      r_stepcnt <= '0;
      r_pcnt    <= '0;
      r_hit     <= 1'b0;
      r_pvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_sel[ADDR_CTRL]) r_ctrl <= ctrl_t'(w_wd[2:0]);
      if (w_sel[ADDR_TARGET]) r_target <= w_wd;
      if (w_sel[ADDR_TIMEOUT]) r_timeout <= w_wd;
      if (w_step & r_pvalid) r_period <= r_pcnt + 32'd1;
      if (avs.avs_cs & avs.avs_read) r_rdata <= w_rdata;
      r_pos     <= w_sel[ADDR_POSITION] ? w_wd : w_pos_wr ? '0 : w_step ? w_pos_next : r_pos;
      r_stepcnt <= w_sel[ADDR_STEPCNT] ? '0 : r_stepcnt + {31'd0, w_step};
      r_pcnt    <= w_step ? '0 : r_pcnt + {31'd0, ~&r_pcnt};
      r_pvalid  <= w_count_rise ? 1'b0 : r_pvalid | w_step;
      // a hit set by a step outranks a same-cycle W1C; a step overridden by a POSITION write cannot hit
      r_hit     <= (w_step & ~w_pos_wr & (w_pos_next == r_target)) |
                   (r_hit & ~(w_sel[ADDR_STATUS] & w_wd[STATUS_HIT]));
    end
  end
endmodule

// File: tb/tb_step_dir_monitor.sv
// tb_step_dir_monitor: random and directed stimulus checked against an event-level model of the monitor
module tb_step_dir_monitor;
  localparam logic [31:0] TO_DEF = 32'd1_000_000;
  logic avs_clk = 1'b0;
  logic avs_reset_n;
  logic step_in, dir_in, en_in, irq;
  step_dir_monitor_if avs ();
  step_dir_monitor dut (
    .avs_clk     (avs_clk),
    .avs_reset_n (avs_reset_n),
    .avs         (avs),
    .step_in     (step_in),
    .dir_in      (dir_in),
    .en_in       (en_in),
    .irq         (irq)
  );
  always #5 avs_clk = ~avs_clk;
  longint cyc = 0;
  always @(posedge avs_clk) cyc <= cyc + 1;
  int n_chk = 0;
  int n_err = 0;
  logic [2:0]  m_ctrl;
  logic [31:0] m_pos, m_period, m_target, m_timeout, m_stepcnt;
  bit          m_hit, m_pvalid, m_stall, m_en, m_dir;
  longint      m_last_rise;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_ctrl = '0; m_pos = '0; m_period = '0; m_target = '0; m_timeout = TO_DEF; m_stepcnt = '0;
    m_hit = 0; m_pvalid = 0; m_stall = 0; m_last_rise = 0;
  endtask
  task automatic m_step(longint rc, bit discard);
    if (!(m_en && m_ctrl[0])) return;
    m_stepcnt = m_stepcnt + 32'd1;
    if (m_pvalid) m_period = 32'(rc - m_last_rise);
    m_pvalid = 1;
    m_last_rise = rc;
    if (!discard) begin
      m_pos = m_pos + ((m_dir ^ m_ctrl[2]) ? 32'd1 : 32'hFFFF_FFFF);
      if (m_pos == m_target) m_hit = 1;
    end
  endtask
  task automatic m_wr(int a, logic [31:0] d);
    case (a)
      0: begin
        if (d[0] && !m_ctrl[0]) m_pvalid = 0;
        m_ctrl = d[2:0];
        if (d[3]) m_pos = '0;
      end
      1: m_pos = d;
      3: m_target = d;
      4: if (d[0]) m_hit = 0;
      5: m_timeout = d;
      6: m_stepcnt = '0;
      default: ;
    endcase
  endtask
  function automatic logic [31:0] m_read(int a);
    case (a)
      0: return {29'd0, m_ctrl};
      1: return m_pos;
      2: return m_period;
      3: return m_target;
      4: return {28'd0, m_en, m_pvalid, m_stall, m_hit};
      5: return m_timeout;
      6: return m_stepcnt;
      default: return 32'h5344_4D31;
    endcase
  endfunction
  task automatic bus_wr(int a, logic [31:0] d);
    avs.avs_cs = 1; avs.avs_write = 1; avs.avs_address = 3'(a); avs.avs_writedata = d;
    @(posedge avs_clk); #1;
    avs.avs_cs = 0; avs.avs_write = 0;
  endtask
  task automatic wr(int a, logic [31:0] d);
    bus_wr(a, d);
    m_wr(a, d);
  endtask
  task automatic bus_rd(int a, output logic [31:0] d);
    avs.avs_cs = 1; avs.avs_read = 1; avs.avs_address = 3'(a);
    @(posedge avs_clk); #1;
    avs.avs_cs = 0; avs.avs_read = 0;
    d = avs.avs_readdata;
  endtask
  task automatic rd_chk(string tag, int a);
    logic [31:0] d;
    bus_rd(a, d);
    chk($sformatf("%s_a%0d", tag, a), d, m_read(a));
  endtask
  task automatic pulse(bit d, bit e, int hi, int lo);
    step_in = 1; dir_in = d; en_in = e; m_dir = d; m_en = e;
    m_step(cyc, 1'b0);
    repeat (hi) @(posedge avs_clk);
    #1 step_in = 0;
    repeat (lo) @(posedge avs_clk);
    #1;
  endtask
  initial begin
    logic [31:0] d, saved;
    avs.avs_cs = 0; avs.avs_read = 0; avs.avs_write = 0; avs.avs_address = '0; avs.avs_writedata = '0;
    step_in = 0; dir_in = 0; en_in = 0; m_en = 0; m_dir = 0;
    avs_reset_n = 0;
    m_reset();
    repeat (3) @(posedge avs_clk);
    #1 avs_reset_n = 1;
    for (int a = 0; a < 8; a++) rd_chk("reset", a);
    chk("reset_irq", 32'(irq), 32'd0);
    bus_rd(7, d);
    chk("id_literal", d, 32'h5344_4D31);
    // ten up pulses, 4 high / 4 low
    wr(0, 32'd1);
    for (int i = 0; i < 10; i++) pulse(1, 1, 4, 4);
    bus_rd(1, d); chk("ten_pos", d, 32'd10);
    bus_rd(6, d); chk("ten_cnt", d, 32'd10);
    bus_rd(2, d); chk("ten_period", d, 32'd8);
    rd_chk("ten_status", 4);
    // readdata holds across a non-read access
    bus_wr(3, 32'd77);
    m_wr(3, 32'd77);
    chk("rd_hold", avs.avs_readdata, m_read(4));
    // read-only addresses ignore writes
    wr(2, 32'hDEAD_BEEF);
    wr(7, 32'h0BAD_F00D);
    rd_chk("ro", 2);
    rd_chk("ro", 7);
    // position wrap both ways
    wr(1, 32'hFFFF_FFFF);
    wr(6, 32'd0);
    pulse(1, 1, 3, 3);
    bus_rd(1, d); chk("wrap_up", d, 32'd0);
    rd_chk("wrap_hit", 4);
    pulse(0, 1, 2, 2);
    pulse(0, 1, 2, 2);
    bus_rd(1, d); chk("wrap_dn", d, 32'hFFFF_FFFE);
    bus_rd(6, d); chk("wrap_cnt", d, 32'd3);
    // target hit, irq timing and W1C
    wr(4, 32'd1);
    wr(3, 32'd5);
    wr(1, 32'd0);
    wr(0, 32'd3);
    for (int i = 0; i < 4; i++) pulse(1, 1, 3, 3);
    chk("irq_pre", 32'(irq), 32'd0);
    step_in = 1; m_step(cyc, 1'b0);
    @(posedge avs_clk); @(posedge avs_clk); #1;
    chk("irq_e2", 32'(irq), 32'd0);
    @(posedge avs_clk); #1;
    chk("irq_e3", 32'(irq), 32'd1);
    step_in = 0;
    repeat (2) @(posedge avs_clk); #1;
    rd_chk("hit_pos", 1);
    chk("irq_sticky", 32'(irq), 32'd1);
    wr(4, 32'd1);
    chk("irq_w1c", 32'(irq), 32'd0);
    // stall detection
    wr(5, 32'd100);
    pulse(1, 1, 3, 3);
    rd_chk("stall0", 4);
    repeat (105) @(posedge avs_clk); #1;
    m_stall = 1;
    rd_chk("stall1", 4);
    pulse(1, 1, 3, 3);
    m_stall = 0;
    rd_chk("stall_clr", 4);
    wr(5, TO_DEF);
    // POSITION write coincident with a counted step
    step_in = 1; m_step(cyc, 1'b1);
    @(posedge avs_clk); @(posedge avs_clk); #1;
    bus_wr(1, 32'h1234_5678);
    m_wr(1, 32'h1234_5678);
    step_in = 0;
    repeat (3) @(posedge avs_clk); #1;
    bus_rd(1, d); chk("coinc_pos", d, 32'h1234_5678);
    rd_chk("coinc_cnt", 6);
    // random traffic
    for (int it = 0; it < 60; it++) begin
      int op, a;
      op = int'($urandom_range(0, 9));
      if (op <= 5) pulse(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
      else if (op == 6) wr(0, {28'd0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0)});
      else if (op == 7) wr(3, m_pos + 32'($urandom_range(0, 4)) - 32'd2);
      else if (op == 8) wr(4, 32'($urandom_range(0, 1)));
      else wr(1, 32'($urandom));
      chk($sformatf("rnd_irq_%0d", it), 32'(irq), {31'd0, m_hit & m_ctrl[1]});
      a = int'($urandom_range(0, 7));
      rd_chk($sformatf("rnd_%0d", it), a);
    end
    rd_chk("rnd_end", 1);
    rd_chk("rnd_end", 6);
    // enable gating
    wr(0, 32'd1);
    bus_rd(1, saved);
    for (int i = 0; i < 5; i++) pulse(1, 0, 2, 2);
    bus_rd(1, d); chk("en_in_off", d, saved);
    wr(0, 32'd0);
    for (int i = 0; i < 5; i++) pulse(1, 1, 2, 2);
    bus_rd(1, d); chk("count_en_off", d, saved);
    rd_chk("gated_cnt", 6);
    // reset mid-step
    wr(0, 32'd1);
    bus_rd(7, d);
    step_in = 1; dir_in = 1; en_in = 1; m_en = 1; m_dir = 1;
    @(posedge avs_clk); #1 avs_reset_n = 0;
    #1;
    chk("async_rdata", avs.avs_readdata, 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    repeat (2) @(posedge avs_clk); #1 avs_reset_n = 1;
    m_reset();
    for (int a = 0; a < 8; a++) rd_chk("rst_mid", a);
    wr(0, 32'd1);
    repeat (5) @(posedge avs_clk); #1 step_in = 0;
    repeat (4) @(posedge avs_clk); #1;
    bus_rd(6, d); chk("rst_lost_cnt", d, 32'd0);
    bus_rd(1, d); chk("rst_lost_pos", d, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
